// File: rtl/dmac_cfg_pkg.sv
// Shared register map, command/status bit positions and channel FSM type
// for the multi-channel DMA configuration register file.
package dmac_cfg_pkg;

    localparam logic [7:0] SRC_OFS       = 8'h00;
    localparam logic [7:0] DST_OFS       = 8'h04;
    localparam logic [7:0] LEN_OFS       = 8'h08;
    localparam logic [7:0] CMD_OFS       = 8'h0C;
    localparam logic [7:0] VERSION_ADDR  = 8'hF0;
    localparam logic [7:0] INT_STAT_ADDR = 8'hF4;
    localparam logic [7:0] INT_MASK_ADDR = 8'hF8;

    localparam int CH_STRIDE     = 16;
    localparam int CMD_START_BIT = 0;
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;

    localparam logic [31:0] VERSION = 32'h0002_0000;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } chState_e;

endpackage

// File: rtl/dmac_cfg_ch.sv
// One DMA channel: SRC/DST/LEN registers, IDLE/BUSY FSM and start pulse.
// Optional alignment check on SRC/DST writes via DMAC_CFG_ALIGN_CHK_EN.
module dmac_cfg_ch
    import dmac_cfg_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wrSrc,
    input  logic             i_wrDst,
    input  logic             i_wrLen,
    input  logic             i_wrCmd,
    input  logic [31:0]      i_wdata,
    input  logic             i_done,
    output logic [31:0]      o_src,
    output logic [31:0]      o_dst,
    output logic [LEN_W-1:0] o_len,
    output logic             o_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_doneEvt
);

    chState_e         r_state;
    chState_e         w_stateNxt;
    logic             w_startAcc;
    logic             w_doneAcc;
    logic             w_unlocked;
    logic             w_aligned;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_len;
    logic             r_start;
    logic             r_done;

`ifdef DMAC_CFG_ALIGN_CHK_EN
    assign w_aligned = (i_wdata[1:0] == 2'b00);
`else
    assign w_aligned = 1'b1;
`endif

    assign w_unlocked = (r_state == CH_IDLE);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= CH_IDLE;
        end else begin
            r_state <= w_stateNxt;
        end
    end

    // In BUSY a start write can never be accepted, so done always wins.
    always_comb begin
        w_stateNxt = r_state;
        w_startAcc = 1'b0;
        w_doneAcc  = 1'b0;
        case (r_state)
            CH_IDLE: begin
                if (i_wrCmd && i_wdata[CMD_START_BIT] && (r_len != '0)) begin
                    w_startAcc = 1'b1;
                    w_stateNxt = CH_BUSY;
                end
            end
            CH_BUSY: begin
                if (i_done) begin
                    w_doneAcc  = 1'b1;
                    w_stateNxt = CH_IDLE;
                end
            end
            default: w_stateNxt = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_unlocked && i_wrSrc && w_aligned) r_src <= i_wdata;
            if (w_unlocked && i_wrDst && w_aligned) r_dst <= i_wdata;
            if (w_unlocked && i_wrLen)              r_len <= i_wdata[LEN_W-1:0];
            r_start <= w_startAcc;
            if (w_startAcc) begin
                r_done <= 1'b0;
            end else if (w_doneAcc) begin
                r_done <= 1'b1;
            end
        end
    end

`ifdef DMAC_CFG_ALIGN_CHK_EN
    logic r_err;

    // Sticky until the next accepted start.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_err <= 1'b0;
        end else if (w_startAcc) begin
            r_err <= 1'b0;
        end else if (w_unlocked && (i_wrSrc || i_wrDst) && !w_aligned) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_src     = r_src;
    assign o_dst     = r_dst;
    assign o_len     = r_len;
    assign o_start   = r_start;
    assign o_busy    = (r_state == CH_BUSY);
    assign o_done    = r_done;
    assign o_doneEvt = w_doneAcc;

endmodule

// File: rtl/dmac_cfg_regfile.sv
// Multi-channel DMA configuration register file: decode, read mux, interrupts.
// Optional SRC/DST alignment check enabled by defining DMAC_CFG_ALIGN_CHK_EN.
module dmac_cfg_regfile
    import dmac_cfg_pkg::*;
#(
    parameter int CH_CNT = 4,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wren_i,
    input  logic                    rden_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [31:0]             wdata_i,
    output logic [31:0]             rdata_o,
    output logic [CH_CNT*32-1:0]    src_o,
    output logic [CH_CNT*32-1:0]    dst_o,
    output logic [CH_CNT*LEN_W-1:0] len_o,
    output logic [CH_CNT-1:0]       start_o,
    input  logic [CH_CNT-1:0]       done_i,
    output logic                    irq_o
);

    localparam int STRIDE_LSB = $clog2(CH_STRIDE);
    localparam int CHW        = ADDR_W - STRIDE_LSB;
    localparam logic [STRIDE_LSB-1:0] OFS_SRC = STRIDE_LSB'(SRC_OFS);
    localparam logic [STRIDE_LSB-1:0] OFS_DST = STRIDE_LSB'(DST_OFS);
    localparam logic [STRIDE_LSB-1:0] OFS_LEN = STRIDE_LSB'(LEN_OFS);
    localparam logic [STRIDE_LSB-1:0] OFS_CMD = STRIDE_LSB'(CMD_OFS);

    logic [ADDR_W-1:0]     w_addr;
    logic [CHW-1:0]        w_chIdx;
    logic [STRIDE_LSB-1:0] w_ofs;
    logic                  w_unusedAddr;
    logic                  w_isVer;
    logic                  w_isStat;
    logic                  w_isMask;
    logic [CH_CNT-1:0]     w_chSel;
    logic [CH_CNT-1:0]     w_busy;
    logic [CH_CNT-1:0]     w_done;
    logic [CH_CNT-1:0]     w_err;
    logic [CH_CNT-1:0]     w_doneEvt;
    logic [CH_CNT-1:0]     w_w1c;
    logic [31:0]           w_src [CH_CNT];
    logic [31:0]           w_dst [CH_CNT];
    logic [LEN_W-1:0]      w_len [CH_CNT];
    logic [31:0]           w_rdData;
    logic [31:0]           r_rdata;
    logic [CH_CNT-1:0]     r_intStat;
    logic [CH_CNT-1:0]     r_intMask;
    logic                  r_irq;

    assign w_addr       = {addr_i[ADDR_W-1:2], 2'b00};
    assign w_unusedAddr = ^addr_i[1:0];
    assign w_chIdx      = w_addr[ADDR_W-1:STRIDE_LSB];
    assign w_ofs        = w_addr[STRIDE_LSB-1:0];
    assign w_isVer      = (w_addr == ADDR_W'(VERSION_ADDR));
    assign w_isStat     = (w_addr == ADDR_W'(INT_STAT_ADDR));
    assign w_isMask     = (w_addr == ADDR_W'(INT_MASK_ADDR));
    assign w_w1c        = (wren_i && w_isStat) ? wdata_i[CH_CNT-1:0] : '0;

    for (genvar n = 0; n < CH_CNT; n++) begin : g_ch
        assign w_chSel[n] = (w_chIdx == CHW'(n));

        dmac_cfg_ch #(
            .LEN_W(LEN_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_wrSrc  (wren_i && w_chSel[n] && (w_ofs == OFS_SRC)),
            .i_wrDst  (wren_i && w_chSel[n] && (w_ofs == OFS_DST)),
            .i_wrLen  (wren_i && w_chSel[n] && (w_ofs == OFS_LEN)),
            .i_wrCmd  (wren_i && w_chSel[n] && (w_ofs == OFS_CMD)),
            .i_wdata  (wdata_i),
            .i_done   (done_i[n]),
            .o_src    (w_src[n]),
            .o_dst    (w_dst[n]),
            .o_len    (w_len[n]),
            .o_start  (start_o[n]),
            .o_busy   (w_busy[n]),
            .o_done   (w_done[n]),
            .o_err    (w_err[n]),
            .o_doneEvt(w_doneEvt[n])
        );

        assign src_o[n*32 +: 32]       = w_src[n];
        assign dst_o[n*32 +: 32]       = w_dst[n];
        assign len_o[n*LEN_W +: LEN_W] = w_len[n];
    end

    // Reads see pre-write state, so a same-cycle write to the read address is invisible.
    always_comb begin
        w_rdData = '0;
        if (w_isVer) begin
            w_rdData = VERSION;
        end else if (w_isStat) begin
            w_rdData = 32'(r_intStat);
        end else if (w_isMask) begin
            w_rdData = 32'(r_intMask);
        end
        for (int n = 0; n < CH_CNT; n++) begin
            if (w_chSel[n]) begin
                case (w_ofs)
                    OFS_SRC: w_rdData = w_src[n];
                    OFS_DST: w_rdData = w_dst[n];
                    OFS_LEN: w_rdData = 32'(w_len[n]);
                    OFS_CMD: begin
                        w_rdData[STAT_BUSY_BIT] = w_busy[n];
                        w_rdData[STAT_DONE_BIT] = w_done[n];
                        w_rdData[STAT_ERR_BIT]  = w_err[n];
                    end
                    default: w_rdData = '0;
                endcase
            end
        end
    end

    // A done event in the same cycle as a W1C clear leaves the bit set.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_rdata   <= '0;
            r_intStat <= '0;
            r_intMask <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (rden_i) r_rdata <= w_rdData;
            if (wren_i && w_isMask) r_intMask <= wdata_i[CH_CNT-1:0];
            r_intStat <= (r_intStat & ~w_w1c) | w_doneEvt;
            r_irq     <= |(r_intStat & r_intMask);
        end
    end

    assign rdata_o = r_rdata;
    assign irq_o   = r_irq;

endmodule

// File: tb/tb_dmac_cfg_regfile.sv
// Directed self-checking bench for dmac_cfg_regfile; covers the
// DMAC_CFG_ALIGN_CHK_EN build when that macro is defined.
module tb_dmac_cfg_regfile;

    localparam int CH_CNT = 4;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 16;

    logic                    clk;
    logic                    rst_n;
    logic                    wren_i;
    logic                    rden_i;
    logic [ADDR_W-1:0]       addr_i;
    logic [31:0]             wdata_i;
    logic [31:0]             rdata_o;
    logic [CH_CNT*32-1:0]    src_o;
    logic [CH_CNT*32-1:0]    dst_o;
    logic [CH_CNT*LEN_W-1:0] len_o;
    logic [CH_CNT-1:0]       start_o;
    logic [CH_CNT-1:0]       done_i;
    logic                    irq_o;

    int vectors    = 0;
    int miscompares = 0;

    dmac_cfg_regfile #(
        .CH_CNT(CH_CNT),
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wren_i (wren_i),
        .rden_i (rden_i),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .rdata_o(rdata_o),
        .src_o  (src_o),
        .dst_o  (dst_o),
        .len_o  (len_o),
        .start_o(start_o),
        .done_i (done_i),
        .irq_o  (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of bus/done activity between two falling edges.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] a,
                                 input logic [31:0] d, input logic [CH_CNT-1:0] dn);
        @(negedge clk);
        wren_i  = wr;
        rden_i  = rd;
        addr_i  = a;
        wdata_i = d;
        done_i  = dn;
        @(negedge clk);
        wren_i  = 1'b0;
        rden_i  = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        done_i  = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic writeReg(input logic [7:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b0, a, d, '0);
    endtask

    task automatic checkRead(input string tag, input logic [7:0] a, input logic [31:0] expected);
        applyStimulus(1'b0, 1'b1, a, 32'h0, '0);
        checkOutput(tag, rdata_o, expected);
    endtask

    task automatic stepCycle();
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b1;
        wren_i  = 1'b0;
        rden_i  = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        done_i  = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_rdata", rdata_o, 32'h0);
        checkOutput("rst_start", 32'(start_o), 32'h0);
        checkOutput("rst_irq", 32'(irq_o), 32'h0);
        checkOutput("rst_src", 32'(|src_o), 32'h0);
        rst_n = 1'b0;

        // Basic R/W, latency/hold, unmapped and out-of-range channel
        writeReg(8'h20, 32'h0123_4567);
        checkRead("ch2_src_rd", 8'h20, 32'h0123_4567);
        stepCycle();
        checkOutput("rdata_hold", rdata_o, 32'h0123_4567);
        checkOutput("ch2_src_o", src_o[95:64], 32'h0123_4567);
        checkRead("unmapped_E0", 8'hE0, 32'h0);
        writeReg(8'h40, 32'hDEAD_BEEF);
        checkRead("ch4_oob_rd", 8'h40, 32'h0);
        checkRead("version", 8'hF0, 32'h0002_0000);

        // ch0 start, lock while busy, done and irq timing
        writeReg(8'h00, 32'h0000_1000);
        writeReg(8'h08, 32'h0000_0040);
        writeReg(8'hF8, 32'h0000_0001);
        checkRead("int_mask_rd", 8'hF8, 32'h1);
        writeReg(8'h0C, 32'h1);
        checkOutput("ch0_start_pulse", 32'(start_o), 32'h1);
        stepCycle();
        checkOutput("ch0_start_end", 32'(start_o), 32'h0);
        checkRead("ch0_stat_busy", 8'h0C, 32'h1);
        writeReg(8'h00, 32'hFFFF_0000);
        checkRead("ch0_src_locked", 8'h00, 32'h0000_1000);
        writeReg(8'h08, 32'h0000_0005);
        checkRead("ch0_len_locked", 8'h08, 32'h0000_0040);
        writeReg(8'h0C, 32'h1);
        checkOutput("ch0_no_restart", 32'(start_o), 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'b0001);
        checkOutput("irq_delay", 32'(irq_o), 32'h0);
        stepCycle();
        checkOutput("irq_set", 32'(irq_o), 32'h1);
        checkRead("ch0_stat_done", 8'h0C, 32'h2);
        checkRead("int_stat_ch0", 8'hF4, 32'h1);

        // W1C and irq deassert
        writeReg(8'hF4, 32'h1);
        stepCycle();
        checkOutput("irq_cleared", 32'(irq_o), 32'h0);
        checkRead("int_stat_w1c", 8'hF4, 32'h0);

        // Restart clears done; W1C coincident with done keeps INT_STAT set
        writeReg(8'h0C, 32'h1);
        checkOutput("ch0_restart_pulse", 32'(start_o), 32'h1);
        checkRead("ch0_stat_restart", 8'h0C, 32'h1);
        applyStimulus(1'b1, 1'b0, 8'hF4, 32'h1, 4'b0001);
        checkRead("int_stat_set_wins", 8'hF4, 32'h1);

        // done coincident with start while busy: done processed, start dropped
        writeReg(8'h0C, 32'h1);
        applyStimulus(1'b1, 1'b0, 8'h0C, 32'h1, 4'b0001);
        checkOutput("done_start_nopulse", 32'(start_o), 32'h0);
        stepCycle();
        checkOutput("done_start_nopulse2", 32'(start_o), 32'h0);
        checkRead("done_start_stat", 8'h0C, 32'h2);

        // Start with LEN==0 ignored; done in IDLE ignored
        writeReg(8'h3C, 32'h1);
        checkOutput("len0_nopulse", 32'(start_o), 32'h0);
        checkRead("len0_stat", 8'h3C, 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 4'b1000);
        checkRead("idle_done_stat", 8'h3C, 32'h0);
        checkRead("idle_done_intstat", 8'hF4, 32'h1);

        // Simultaneous read and write of one address returns old value
        writeReg(8'h10, 32'hAAAA_0000);
        applyStimulus(1'b1, 1'b1, 8'h10, 32'h5555_0004, '0);
        checkOutput("rw_same_old", rdata_o, 32'hAAAA_0000);
        checkRead("rw_same_new", 8'h10, 32'h5555_0004);
        checkRead("addr_lsb_ignored", 8'h13, 32'h5555_0004);

        // Reset asserted mid-transfer on ch1
        writeReg(8'h18, 32'h0000_0010);
        writeReg(8'h1C, 32'h1);
        checkOutput("ch1_start_pulse", 32'(start_o), 32'h2);
        stepCycle();
        checkRead("ch1_busy", 8'h1C, 32'h1);
        checkOutput("pre_rst_irq", 32'(irq_o), 32'h1);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("async_rst_rdata", rdata_o, 32'h0);
        checkOutput("async_rst_irq", 32'(irq_o), 32'h0);
        checkOutput("async_rst_len", 32'(|len_o), 32'h0);
        checkOutput("async_rst_src", 32'(|src_o), 32'h0);
        checkOutput("async_rst_start", 32'(start_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        checkRead("ch1_stat_after_rst", 8'h1C, 32'h0);

`ifdef DMAC_CFG_ALIGN_CHK_EN
        writeReg(8'h04, 32'h0000_1000);
        writeReg(8'h04, 32'h0000_1002);
        checkRead("align_dst_kept", 8'h04, 32'h0000_1000);
        checkRead("align_err_set", 8'h0C, 32'h4);
        writeReg(8'h08, 32'h0000_0008);
        writeReg(8'h0C, 32'h1);
        checkRead("align_err_cleared", 8'h0C, 32'h1);
`else
        writeReg(8'h04, 32'h0000_1002);
        checkRead("noalign_dst", 8'h04, 32'h0000_1002);
        checkRead("noalign_err", 8'h0C, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmac_cfg_regfile.md
Name: dmac_cfg_regfile

Overview:
Parametrised multi-channel DMA configuration register file; successor to the single-register DMAC_CFG.
Holds per-channel SRC/DST/LEN registers, a start/status register, and global interrupt status/mask/version registers.
Provides a simple wren/rden/addr CPU-side interface toward software and per-channel start/done handshakes toward the DMA engines.

Parameters:
CH_CNT, 4, number of DMA channels (1..8)
ADDR_W, 8, byte-address width of register space
LEN_W, 16, transfer-length field width

Ports:
clk  input  1  clock
rst_n  input  1  reset
wren_i  input  1  write strobe, one-cycle
rden_i  input  1  read strobe, one-cycle
addr_i  input  ADDR_W  byte address, word-aligned (bits[1:0] ignored)
wdata_i  input  32  write data
rdata_o  output  32  read data, registered
src_o  output  CH_CNT*32  per-channel source address, ch0 in LSBs
dst_o  output  CH_CNT*32  per-channel destination address
len_o  output  CH_CNT*LEN_W  per-channel byte length
start_o  output  CH_CNT  one-cycle start pulse per channel
done_i  input  CH_CNT  one-cycle completion pulse per channel
irq_o  output  1  interrupt, registered

Behaviour:
- Reset: rst_n asynchronous, active-high; clock clk. While asserted, every register and output is 0 (rdata_o, src_o, dst_o, len_o, start_o, irq_o).
- Map, channel n at base n*0x10:
  - +0x0 SRC, R/W.
  - +0x4 DST, R/W.
  - +0x8 LEN, R/W, LEN_W bits, upper bits read 0.
  - +0xC CMD/STAT: write bit0=start. Read bit0=busy, bit1=done, bit2=err.
- Global registers:
  - 0xF0 VERSION: RO, package constant.
  - 0xF4 INT_STAT: bit n = channel n done. Write-1-to-clear.
  - 0xF8 INT_MASK: R/W, CH_CNT bits.
- Unmapped addresses and channels >= CH_CNT: writes dropped, reads return 0.
- Writes take effect at the posedge where wren_i=1.
- Reads: rdata_o updates at the posedge where rden_i=1 and holds until the next read (1-cycle latency).
  - Simultaneous wren_i and rden_i to the same address: read returns the pre-write value.
- Per-channel FSM IDLE -> BUSY:
  - IDLE: a CMD write with bit0=1 and LEN!=0 pulses start_o[n] for exactly one cycle on the next cycle, sets busy, clears done and err, and moves to BUSY.
  - Start with LEN==0: ignored, no pulse.
  - BUSY: SRC/DST/LEN/CMD writes are ignored (registers locked). done_i[n] clears busy, sets done and INT_STAT[n], and returns to IDLE.
  - done_i in IDLE: ignored.
  - done_i coincident with a start write while BUSY: done processed, start discarded.
- INT_STAT set and a W1C clear in the same cycle: set wins.
- irq_o = |(INT_STAT & INT_MASK), registered; 1-cycle delay after the INT_STAT change.
- Reset asserted mid-transfer: all busy cleared immediately; no start_o pulse emitted.

Optional Feature:
DMAC_CFG_ALIGN_CHK_EN
- Defined: SRC/DST writes with wdata_i[1:0]!=0 are dropped and set that channel's err bit (sticky until the next accepted start).
- Undefined: any value is written and err always reads 0.

Decomposition:
- Package dmac_cfg_pkg: register offset localparams (SRC/DST/LEN/CMD/VERSION/INT_STAT/INT_MASK), CMD bit positions, VERSION constant 0x0002_0000, channel stride 0x10, typedef for the channel FSM state enum.
- Sub-module dmac_cfg_ch: one channel's SRC/DST/LEN/FSM and start pulse, instantiated CH_CNT times by generate.
- Top level: address decode, read mux, INT_STAT/INT_MASK, irq_o.

Test Plan:
1. Write ch2 SRC=0x0123_4567, then read 0x20 next cycle -> rdata_o=0x0123_4567 one cycle after rden_i. Read unmapped 0xE0 -> 0.
2. ch0 LEN=0x40, CMD=1 -> start_o[0] single pulse, STAT busy=1. Write SRC=0xFFFF_0000 while busy -> SRC unchanged. done_i[0] -> STAT=0x2, INT_STAT=0x1.
3. INT_MASK=0x1 with ch0 done -> irq_o=1 one cycle after INT_STAT set. W1C 0x1 -> irq_o=0. W1C coincident with a new done_i[0] -> INT_STAT stays 1.
4. CMD=1 with LEN=0 -> no start_o, busy=0. Second CMD=1 while busy -> no second pulse.
5. Assert rst_n mid-BUSY on ch1 -> all outputs 0 asynchronously. After release, STAT ch1=0.
6. With DMAC_CFG_ALIGN_CHK_EN: write DST=0x1002 -> DST unchanged, err=1. Next valid start -> err=0.
